// File: rtl/r_inv_pkg.sv
// Shared constants, element type and feeder state encoding for the
// triangular-matrix inverse front end.
package r_inv_pkg;
  localparam int DW = 16;
  localparam int N  = 3;
  localparam int E  = N * (N + 1) / 2;
  localparam int P  = (E + 1) / 2;
  localparam int CW = (E > 1) ? $clog2(E) : 1;
  localparam int PW = (P > 1) ? $clog2(P) : 1;

  // Signed Q4.12 element when DW=16.
  typedef logic signed [DW-1:0] elem_t;

  typedef enum logic [2:0] {
    LOAD       = 3'd0,
    PAIR_SETUP = 3'd1,
    PAIR_VALID = 3'd2,
    PAIR_WAIT  = 3'd3,
    START      = 3'd4,
    START_WAIT = 3'd5
  } feed_state_e;

  // Diagonal positions in row-major upper-triangular order: 0, N, 2N-1, ...
  function automatic logic is_diag(input int idx);
    logic hit;
    int   d;
    hit = 1'b0;
    d   = 0;
    for (int i = 0; i < N; i++) begin
      if (idx == d) hit = 1'b1;
      d = d + (N - i);
    end
    return hit;
  endfunction
endpackage

// File: rtl/r_mat_regfile.sv
// E-entry R-element store: one write port, two combinational pair read ports
// (2*pair, 2*pair+1) with zero padding past the last element.
module r_mat_regfile
  import r_inv_pkg::*;
(
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          i_we,
  input  logic [CW-1:0] i_waddr,
  input  elem_t         i_wdata,
  input  logic [PW-1:0] i_pair,
  output elem_t         o_rd0,
  output elem_t         o_rd1
);
  elem_t        r_mem [E];
  logic [PW:0]  w_idx0;
  logic [PW:0]  w_idx1;

  assign w_idx0 = {i_pair, 1'b0};
  assign w_idx1 = {i_pair, 1'b1};

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < E; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rd0 = '0;
    o_rd1 = '0;
    if (int'(w_idx0) < E) o_rd0 = r_mem[w_idx0];
    if (int'(w_idx1) < E) o_rd1 = r_mem[w_idx1];
  end
endmodule

// File: rtl/r_mat_feeder.sv
// Captures the upper-triangular R matrix and replays it to the inverse block
// in pairs, then issues start. Optional zero-diagonal check: R_DIAG_CHECK_EN.
module r_mat_feeder
  import r_inv_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_n,
  input  elem_t       qr_data,
  input  logic        qr_valid,
  output logic        qr_ready,
  input  logic        done_inverse,
  output elem_t       regfile_out1,
  output elem_t       regfile_out2,
  output logic        valid_inverse,
  output logic        start_inverse,
  output logic        feed_busy,
`ifdef R_DIAG_CHECK_EN
  output logic        singular_err,
`endif
  output logic        mat_done,
  output feed_state_e dbg_state
);
  // Handshake: an element moves on a rising CLK edge with qr_valid=1 and
  // qr_ready=1; valid_inverse/start_inverse are single-cycle strobes that are
  // acknowledged only by a rising edge of done_inverse.
  feed_state_e   r_state;
  feed_state_e   w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_pair;
  logic          r_done_q;
  logic          w_ack;
  logic          w_accept;
  logic          w_last;
  logic          w_sing;
  elem_t         w_rd0;
  elem_t         w_rd1;

  assign w_ack     = done_inverse & ~r_done_q;
  assign w_accept  = qr_valid & qr_ready;
  assign w_last    = w_accept && (r_cnt == CW'(E - 1));
  assign dbg_state = r_state;

`ifdef R_DIAG_CHECK_EN
  logic r_sing_flag;
  logic w_diag_zero;

  assign w_diag_zero = w_accept && is_diag(int'(r_cnt)) && (qr_data == '0);
  assign w_sing      = w_last && (r_sing_flag || w_diag_zero);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_sing_flag  <= 1'b0;
      singular_err <= 1'b0;
    end else begin
      singular_err <= w_sing;
      if (w_last)           r_sing_flag <= 1'b0;
      else if (w_diag_zero) r_sing_flag <= 1'b1;
    end
  end
`else
  assign w_sing = 1'b0;
`endif

  r_mat_regfile u_regfile (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .i_we    (w_accept),
    .i_waddr (r_cnt),
    .i_wdata (qr_data),
    .i_pair  (r_pair),
    .o_rd0   (w_rd0),
    .o_rd1   (w_rd1)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD:       if (w_last && !w_sing) w_state_nxt = PAIR_SETUP;
      PAIR_SETUP: w_state_nxt = PAIR_VALID;
      PAIR_VALID: w_state_nxt = PAIR_WAIT;
      PAIR_WAIT:  if (w_ack) w_state_nxt = (r_pair == PW'(P - 1)) ? START : PAIR_SETUP;
      START:      w_state_nxt = START_WAIT;
      START_WAIT: if (w_ack) w_state_nxt = LOAD;
      default:    w_state_nxt = LOAD;
    endcase
  end

  // Outputs are decoded from the next state so every strobe is a flop.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state       <= LOAD;
      r_cnt         <= '0;
      r_pair        <= '0;
      r_done_q      <= 1'b0;
      qr_ready      <= 1'b1;
      feed_busy     <= 1'b0;
      valid_inverse <= 1'b0;
      start_inverse <= 1'b0;
      mat_done      <= 1'b0;
      regfile_out1  <= '0;
      regfile_out2  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_done_q      <= done_inverse;
      qr_ready      <= (w_state_nxt == LOAD);
      feed_busy     <= (w_state_nxt != LOAD);
      valid_inverse <= (w_state_nxt == PAIR_VALID);
      start_inverse <= (w_state_nxt == START);
      mat_done      <= ((r_state == START_WAIT) && w_ack) || w_sing;
      if (w_accept) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last)
        r_pair <= '0;
      else if ((r_state == PAIR_WAIT) && w_ack && (r_pair != PW'(P - 1)))
        r_pair <= r_pair + 1'b1;
      // Pair data is latched once and then held until the next setup.
      if (r_state == PAIR_SETUP) begin
        regfile_out1 <= w_rd0;
        regfile_out2 <= w_rd1;
      end
    end
  end
endmodule

// File: tb/tb_r_mat_feeder.sv
// Randomized bench for r_mat_feeder against a pair-list model of the matrix
// replay; build with +define+R_DIAG_CHECK_EN to cover the singular check.
module tb_r_mat_feeder;
  import r_inv_pkg::*;

  logic            CLK = 1'b0;
  logic            RST_n;
  logic [DW-1:0]   qr_data;
  logic            qr_valid;
  logic            qr_ready;
  logic            done_inverse;
  logic [DW-1:0]   regfile_out1;
  logic [DW-1:0]   regfile_out2;
  logic            valid_inverse;
  logic            start_inverse;
  logic            feed_busy;
  logic            mat_done;
  feed_state_e     dbg_state;
`ifdef R_DIAG_CHECK_EN
  logic            singular_err;
`endif

  int n_checks  = 0;
  int n_fail    = 0;
  int n_valid   = 0;
  int n_start   = 0;
  int n_done    = 0;
  int hold_left = 0;

  logic [DW-1:0]   mat [E];
  logic [2*DW-1:0] exp_q [$];

  r_mat_feeder dut (
    .CLK           (CLK),
    .RST_n         (RST_n),
    .qr_data       (qr_data),
    .qr_valid      (qr_valid),
    .qr_ready      (qr_ready),
    .done_inverse  (done_inverse),
    .regfile_out1  (regfile_out1),
    .regfile_out2  (regfile_out2),
    .valid_inverse (valid_inverse),
    .start_inverse (start_inverse),
    .feed_busy     (feed_busy),
`ifdef R_DIAG_CHECK_EN
    .singular_err  (singular_err),
`endif
    .mat_done      (mat_done),
    .dbg_state     (dbg_state)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One cycle: sample on the falling edge, count strobes, run the ack responder.
  task automatic tick();
    @(negedge CLK);
    if (valid_inverse) n_valid++;
    if (start_inverse) n_start++;
    if (mat_done)      n_done++;
    if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 1) done_inverse = 1'b0;
    end
  endtask

  // Raise done_inverse for `hold` clock edges, guaranteeing a low cycle before it.
  task automatic send_ack(input int hold);
    while (hold_left > 0) tick();
    done_inverse = 1'b1;
    hold_left    = hold + 1;
  endtask

  task automatic wait_strobe(input int which, input int exp_lat, input string tag);
    int   k;
    logic seen;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 30) begin
      tick();
      k++;
      seen = (which == 0) ? valid_inverse : (which == 1) ? start_inverse : mat_done;
    end
    chk(tag, k, exp_lat);
  endtask

  // Reference: pairs are consecutive elements, the odd tail padded with zero.
  task automatic build_expected();
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    exp_q.delete();
    for (int p = 0; p < P; p++) begin
      a = mat[2*p];
      b = (2*p + 1 < E) ? mat[2*p + 1] : '0;
      exp_q.push_back({a, b});
    end
  endtask

  function automatic bit exp_singular();
    bit s;
    s = 1'b0;
    for (int i = 0; i < N; i++)
      if (mat[i*N - (i*(i-1))/2] == '0) s = 1'b1;
    return s;
  endfunction

  task automatic randomize_mat();
    for (int i = 0; i < E; i++) mat[i] = DW'($urandom);
  endtask

  task automatic load_matrix(input int gap_max, input bit sing);
    int g;
    for (int i = 0; i < E; i++) begin
      g = $urandom_range(0, gap_max);
      repeat (g) tick();
      chk("ready_load", qr_ready, 1'b1);
      qr_valid = 1'b1;
      qr_data  = mat[i];
      tick();
      qr_valid = 1'b0;
    end
    chk("ready_after_last", {qr_ready, feed_busy}, sing ? 2'b10 : 2'b01);
  endtask

  task automatic run_matrix(input int gap_max, input int ack_dly, input int hold,
                            input int start_dly, input bit junk, input int abort_at);
    int              b_valid;
    int              b_start;
    int              b_done;
    bit              sing;
    logic [2*DW-1:0] cur;
    b_valid = n_valid;
    b_start = n_start;
    b_done  = n_done;
    sing    = exp_singular();
    build_expected();
`ifdef R_DIAG_CHECK_EN
    load_matrix(gap_max, sing);
    if (sing) begin
      chk("sing_pulse", {singular_err, mat_done}, 2'b11);
      tick();
      chk("sing_clear", {singular_err, mat_done, qr_ready}, 3'b001);
      repeat (4) tick();
      chk("sing_no_pair", n_valid - b_valid, 0);
      chk("sing_no_start", n_start - b_start, 0);
      chk("sing_done_cnt", n_done - b_done, 1);
      return;
    end
`else
    load_matrix(gap_max, 1'b0);
`endif
    cur = '0;
    for (int p = 0; p < P; p++) begin
      wait_strobe(0, (p == 0) ? 1 : 2, "pair_latency");
      cur = exp_q.pop_front();
      chk("pair_data", {regfile_out1, regfile_out2}, cur);
      if (p == abort_at) return;
      for (int k = 0; k < ack_dly; k++) begin
        if (junk) begin
          qr_valid = ($urandom_range(0, 1) == 1);
          qr_data  = DW'($urandom);
        end
        tick();
        chk("pair_hold", {regfile_out1, regfile_out2}, cur);
        chk("pair_wait_flags", {qr_ready, feed_busy, valid_inverse}, 3'b010);
      end
      qr_valid = 1'b0;
      send_ack(hold);
    end
    wait_strobe(1, 1, "start_latency");
    chk("start_hold", {regfile_out1, regfile_out2}, cur);
    for (int k = 0; k < start_dly; k++) begin
      tick();
      chk("start_wait_flags", {qr_ready, feed_busy, start_inverse}, 3'b010);
    end
    send_ack(hold);
    wait_strobe(2, 1, "done_latency");
    chk("done_flags", {qr_ready, feed_busy}, 2'b10);
    chk("out_kept", {regfile_out1, regfile_out2}, cur);
    tick();
    chk("done_pulse", mat_done, 1'b0);
    while (hold_left > 0) tick();
    tick();
    chk("pair_count", n_valid - b_valid, P);
    chk("start_count", n_start - b_start, 1);
    chk("done_count", n_done - b_done, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {regfile_out1, regfile_out2, valid_inverse, start_inverse,
              feed_busy, mat_done, qr_ready}, {{(2*DW){1'b0}}, 5'b00001});
    chk({tag, "_state"}, dbg_state, LOAD);
`ifdef R_DIAG_CHECK_EN
    chk({tag, "_sing"}, singular_err, 1'b0);
`endif
  endtask

  initial begin
    int b_valid;
    RST_n        = 1'b0;
    qr_valid     = 1'b0;
    qr_data      = '0;
    done_inverse = 1'b0;
    repeat (2) tick();
    chk_reset_outputs("reset");
    RST_n = 1'b1;
    tick();

    // all elements 4.0, back to back, slow start ack
    for (int i = 0; i < E; i++) mat[i] = 16'h4000;
    run_matrix(0, 3, 1, 10, 1'b0, P);

    // distinct ramp with input gaps and dropped beats while busy
    for (int i = 0; i < E; i++) mat[i] = DW'((i + 1) * 16'h1000);
    run_matrix(3, 2, 1, 4, 1'b1, P);

    // done pulse while loading is ignored
    b_valid = n_valid;
    send_ack(2);
    while (hold_left > 0) tick();
    repeat (3) tick();
    chk("load_ack_ignored", {n_valid - b_valid, 30'd0, qr_ready, feed_busy}, {32'd0, 30'd0, 2'b10});

    // level done held five cycles advances one pair at a time
    randomize_mat();
    run_matrix(1, 3, 5, 3, 1'b0, P);

    // reset while waiting on pair 1, then a full reload from index 0
    randomize_mat();
    run_matrix(0, 2, 1, 2, 1'b0, 1);
    tick();
    RST_n = 1'b0;
    done_inverse = 1'b0;
    hold_left = 0;
    #1;
    chk_reset_outputs("mid_reset");
    tick();
    RST_n = 1'b1;
    repeat (3) tick();
    chk("post_reset_quiet", {valid_inverse, start_inverse, mat_done}, 3'b000);
    randomize_mat();
    run_matrix(1, 2, 1, 2, 1'b0, P);

    // zero diagonal r22: forwarded, or flagged singular when the check is built in
    randomize_mat();
    mat[N] = '0;
    run_matrix(0, 2, 1, 2, 1'b0, P);
    randomize_mat();
    run_matrix(0, 2, 1, 2, 1'b0, P);

    for (int r = 0; r < 6; r++) begin
      randomize_mat();
      run_matrix($urandom_range(0, 3), $urandom_range(1, 6), $urandom_range(1, 5),
                 $urandom_range(0, 8), 1'b1, P);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
